stage_ex_mdu: RTL
=================

Name: stage_ex_mdu

Overview:
Parametrised execute stage for the 5-stage RV32 pipeline. Sits between ID/EX and EX/MEM and keeps single-cycle ALU, forwarding, operand-mux and jump-link behaviour. Adds an iterative multiply/divide unit (RV32M) with a stall handshake to the hazard unit. XLEN is generalised.

Parameters:
XLEN, 32, datapath width (power of two, >=8)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_valid  in  1  ID/EX holds a live instruction
i_flush  in  1  kill the in-flight EX instruction (branch redirect)
i_pc  in  XLEN  instruction PC
i_rs1_val  in  XLEN  RF rs1
i_rs2_val  in  XLEN  RF rs2
i_imm  in  XLEN  immediate
i_alu_op  in  4  ALU opcode (existing encoding)
i_op_a_sel  in  2  00 rs1, 01 PC, 10 zero, 11 rs1
i_op_b_sel  in  1  0 rs2, 1 imm
i_is_jump  in  1  JAL/JALR; result = PC+4
i_is_md  in  1  M-extension instruction
i_md_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_forward_a_sel  in  2  00 RF, 01 WB, 10 EX/MEM, 11 RF
i_forward_b_sel  in  2  same as a
i_ex_mem_alu_result  in  XLEN  EX/MEM forward source
i_wb_write_data  in  XLEN  WB forward source
o_alu_result  out  XLEN  result to EX/MEM
o_store_data  out  XLEN  forwarded rs2
o_valid  out  1  EX/MEM may capture this cycle
o_stall  out  1  hold IF/ID/ID-EX, insert bubble into EX/MEM

Behaviour:
- Reset (async): state IDLE, counter, operand, accumulator, sign and result registers = 0. o_stall=0, o_valid=0. o_alu_result and o_store_data are then driven only by the combinational path.
- Non-MD path (i_is_md=0): fully combinational, zero latency. Forward mux, then operand mux, then ALU. o_alu_result = i_is_jump ? i_pc+4 : ALU result (mod 2^XLEN). o_store_data = forwarded rs2. o_valid = i_valid & ~i_flush.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On i_valid & i_is_md & ~i_flush, capture forwarded rs1/rs2 (never op_a/op_b). Operands are latched only at issue; forward inputs are ignored afterwards.
  - o_stall=1 combinationally in this issue cycle.
  - Next state: MUL for md_op[2]=0, DIV otherwise.
- MUL: radix-2 shift-add on |a|,|b| per signedness (MULHSU: rs1 signed, rs2 unsigned). XLEN cycles producing a 2*XLEN product. Negate if signs differ. MUL returns the low half; MULH* return the high half.
- DIV: restoring divide on magnitudes, XLEN cycles. Quotient sign = sa^sb; remainder sign = sa.
- DIV special cases are resolved at issue and go to DONE after 1 cycle:
  - Divide-by-zero: quotient = all-ones, remainder = dividend.
  - Signed overflow (min / -1): quotient = min, remainder = 0.
- DONE: result register drives o_alu_result; o_stall=0; o_valid=1. The upstream stage advances the same cycle. Return to IDLE.
- Latency: stall high for XLEN+1 cycles (issue + XLEN iterations); result is in cycle XLEN+1 after issue.
- o_stall is high in IDLE-issue, MUL and DIV; low in DONE and in idle non-MD cycles.
- o_valid = 0 while o_stall=1.
- i_flush in any state: o_stall=0 and o_valid=0 combinationally; next state IDLE; iteration discarded. Flush overrides a same-cycle issue.
- i_reset mid-operation: immediate abort to reset values. No result is produced.
- Back-to-back MD instructions: the second issues in the cycle after DONE, when ID/EX presents it (IDLE).
- Store data during MD: o_store_data follows the combinational forward of current inputs; MD instructions never store.

Optional Feature:
EX_FAST_MUL_EN
- Defined: MUL ops use a single combinational 2*XLEN signed/unsigned multiplier, registered at issue. MUL ops go IDLE, DONE with o_stall high for 1 cycle.
- Undefined: iterative multiplier as above, XLEN+1 stall cycles. DIV behaviour is identical in both builds.

Test Plan:
- ADD, rs1 fwd EX/MEM=5, rs2 RF=7, op_b_sel=0 -> same-cycle o_alu_result=12, o_valid=1, o_stall=0.
- JAL pc=0x100, is_jump=1 -> o_alu_result=0x104 regardless of ALU.
- MULH rs1=0x80000000, rs2=2 -> o_stall high 33 cycles, then o_alu_result=0xFFFFFFFF, o_valid=1 (fast build: 1 stall cycle).
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0, stall 1 cycle.
- DIVU 100/3 issued, i_flush at cycle 10 -> o_stall=0 that cycle, no o_valid; next MUL 3*4 -> 12 correct.
- i_reset asserted mid-DIV (no clock edge) -> o_stall=0 immediately; after release the ADD path is correct.

Source files
------------

// File: rtl/stage_ex_mdu.sv
// RV32 execute stage: forwarding, operand mux, single-cycle ALU and jump link,
// plus an iterative RV32M multiply/divide unit that stalls the front end while busy.
// Optional `EX_FAST_MUL_EN: multiplies use one combinational multiplier and finish in one stall cycle.
module stage_ex_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [XLEN-1:0] i_imm,
    input  logic [3:0]      i_alu_op,
    input  logic [1:0]      i_op_a_sel,
    input  logic            i_op_b_sel,
    input  logic            i_is_jump,
    input  logic            i_is_md,
    input  logic [2:0]      i_md_op,
    input  logic [1:0]      i_forward_a_sel,
    input  logic [1:0]      i_forward_b_sel,
    input  logic [XLEN-1:0] i_ex_mem_alu_result,
    input  logic [XLEN-1:0] i_wb_write_data,
    output logic [XLEN-1:0] o_alu_result,
    output logic [XLEN-1:0] o_store_data,
    output logic            o_valid,
    output logic            o_stall
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;
    logic                neg_q;
    logic                neg_r;
    logic [2:0]          md_op_q;
    logic [XLEN-1:0]     result_q;

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, comb_result;
    logic [SH_W-1:0] shamt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        fwd_a = i_rs1_val;
        fwd_b = i_rs2_val;
        case (i_forward_a_sel)
            2'b01:   fwd_a = i_wb_write_data;
            2'b10:   fwd_a = i_ex_mem_alu_result;
            default: fwd_a = i_rs1_val;
        endcase
        case (i_forward_b_sel)
            2'b01:   fwd_b = i_wb_write_data;
            2'b10:   fwd_b = i_ex_mem_alu_result;
            default: fwd_b = i_rs2_val;
        endcase
    end

    always_comb begin
        op_a = fwd_a;
        case (i_op_a_sel)
            2'b01:   op_a = i_pc;
            2'b10:   op_a = '0;
            default: op_a = fwd_a;
        endcase
        op_b  = i_op_b_sel ? i_imm : fwd_b;
        shamt = op_b[SH_W-1:0];
    end

    always_comb begin
        alu_res = '0;
        case (i_alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_PASS: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    assign comb_result = i_is_jump ? i_pc + XLEN'(4) : alu_res;

    // Issue-time operand preparation: MULHSU treats rs2 as unsigned, *U ops treat both as unsigned.
    logic            issue, a_signed, b_signed, sa, sb, div_by_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign issue       = (state == S_IDLE) & i_valid & i_is_md & ~i_flush & ~i_reset;
    assign a_signed    = (i_md_op != 3'b011) & (i_md_op != 3'b101) & (i_md_op != 3'b111);
    assign b_signed    = a_signed & (i_md_op != 3'b010);
    assign sa          = a_signed & fwd_a[XLEN-1];
    assign sb          = b_signed & fwd_b[XLEN-1];
    assign a_mag       = sa ? -fwd_a : fwd_a;
    assign b_mag       = sb ? -fwd_b : fwd_b;
    assign div_by_zero = (fwd_b == '0);
    assign div_ovf     = ~i_md_op[0] & (fwd_a == MIN_VAL) & (fwd_b == '1);

    // One shift-add multiply step: multiplier sits in acc low half, product grows in from the top.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_final;
    logic [XLEN-1:0]   mul_pick;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign mul_final = neg_q ? -mul_next : mul_next;
    assign mul_pick  = (md_op_q == 3'b000) ? mul_final[XLEN-1:0] : mul_final[2*XLEN-1:XLEN];

    // One restoring divide step: remainder in acc high half, dividend/quotient bits in the low half.
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem_next, div_quo_next, div_pick;

    assign div_shift    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff     = div_shift - {1'b0, opnd};
    assign div_ge       = div_shift >= {1'b0, opnd};
    assign div_rem_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_quo_next = {acc[XLEN-2:0], div_ge};
    assign div_pick     = md_op_q[1] ? (neg_r ? -div_rem_next : div_rem_next)
                                     : (neg_q ? -div_quo_next : div_quo_next);

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a_ext, fast_b_ext, fast_prod;
    logic [XLEN-1:0]   fast_pick;

    assign fast_a_ext = {{XLEN{sa}}, fwd_a};
    assign fast_b_ext = {{XLEN{sb}}, fwd_b};
    assign fast_prod  = fast_a_ext * fast_b_ext;
    assign fast_pick  = (i_md_op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            md_op_q  <= '0;
            result_q <= '0;
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        md_op_q <= i_md_op;
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        cnt     <= CNT_W'(XLEN);
                        if (!i_md_op[2]) begin
`ifdef EX_FAST_MUL_EN
                            result_q <= fast_pick;
                            state    <= S_DONE;
`else
                            opnd  <= a_mag;
                            acc   <= {{XLEN{1'b0}}, b_mag};
                            state <= S_MUL;
`endif
                        end else if (div_by_zero) begin
                            result_q <= i_md_op[1] ? fwd_a : '1;
                            state    <= S_DONE;
                        end else if (div_ovf) begin
                            result_q <= i_md_op[1] ? '0 : MIN_VAL;
                            state    <= S_DONE;
                        end else begin
                            opnd  <= b_mag;
                            acc   <= {{XLEN{1'b0}}, a_mag};
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_q <= mul_pick;
                        state    <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc <= {div_rem_next, div_quo_next};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_q <= div_pick;
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Flush and reset silence the handshake immediately, without waiting for a clock edge.
    always_comb begin
        o_stall      = 1'b0;
        o_valid      = 1'b0;
        o_alu_result = comb_result;
        if (!i_flush && !i_reset) begin
            case (state)
                S_IDLE: begin
                    o_stall = i_valid & i_is_md;
                    o_valid = i_valid & ~i_is_md;
                end
                S_MUL, S_DIV: o_stall = 1'b1;
                S_DONE: begin
                    o_valid      = 1'b1;
                    o_alu_result = result_q;
                end
                default: ;
            endcase
        end
    end

    assign o_store_data = fwd_b;

endmodule
